// File: rtl/o_buf_pkg.sv
// Shared types and sizing for the eight-word output buffer.
// Imported by the index counter and the buffer top.
package o_buf_pkg;

    localparam int O_BUF_DEPTH = 8;
    localparam int O_BUF_IDX_W = 3;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } o_buf_state_t;

endpackage

// File: rtl/output_buffer_if.sv
// Upstream/downstream handshake bundle of the output buffer.
// master drives words in and ready out; slave is the buffer side.
interface output_buffer_if #(
    parameter int DATA_W = 16
);

    logic              In_valid;
    logic [DATA_W-1:0] In_data;
    logic              In_ready;
    logic              Out_valid;
    logic [DATA_W-1:0] Out_data;
    logic              Out_ready;
    logic              Out_last;
    logic              Busy;

    modport master (
        output In_valid, In_data, Out_ready,
        input  In_ready, Out_valid, Out_data, Out_last, Busy
    );

    modport slave (
        input  In_valid, In_data, Out_ready,
        output In_ready, Out_valid, Out_data, Out_last, Busy
    );

endinterface

// File: rtl/o_buf_idx_counter.sv
// Enable-gated index counter for the buffer; the 3-bit width
// makes the 7 -> 0 wrap free.
module o_buf_idx_counter
    import o_buf_pkg::*;
(
    input  logic                   Clock,
    input  logic                   Res_o_buf,
    input  logic                   en,
    output logic [O_BUF_IDX_W-1:0] idx
);

    // Advance by one on each enabled edge.
    always_ff @(posedge Clock or negedge Res_o_buf) begin
        if (!Res_o_buf) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/output_buffer.sv
// Eight-word block buffer: fills a block, then drains it in order.
// Optional sticky overrun flag Ovf_err under O_BUF_OVF_FLAG_EN.
module output_buffer
    import o_buf_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Res_o_buf,
    input  logic              In_valid,
    input  logic [DATA_W-1:0] In_data,
    output logic              In_ready,
    output logic              Out_valid,
    output logic [DATA_W-1:0] Out_data,
    input  logic              Out_ready,
    output logic              Out_last,
    output logic              Busy
`ifdef O_BUF_OVF_FLAG_EN
    ,
    output logic              Ovf_err
`endif
);

    localparam logic [O_BUF_IDX_W-1:0] IDX_LAST =
        O_BUF_IDX_W'(O_BUF_DEPTH - 1);

    o_buf_state_t             state;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic [O_BUF_IDX_W-1:0]   wr_idx;
    logic [O_BUF_IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]        entry [O_BUF_DEPTH];
    logic                     in_xfer;
    logic                     out_xfer;

    assign in_xfer  = In_valid && in_ready_q;
    assign out_xfer = out_valid_q && Out_ready;

    o_buf_idx_counter u_wr_idx (
        .Clock     (Clock),
        .Res_o_buf (Res_o_buf),
        .en        (in_xfer),
        .idx       (wr_idx)
    );

    o_buf_idx_counter u_rd_idx (
        .Clock     (Clock),
        .Res_o_buf (Res_o_buf),
        .en        (out_xfer),
        .idx       (rd_idx)
    );

    // Capture accepted words; reset clears the whole block.
    always_ff @(posedge Clock or negedge Res_o_buf) begin
        if (!Res_o_buf) begin
            for (int i = 0; i < O_BUF_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (in_xfer) begin
            entry[wr_idx] <= In_data;
        end
    end

    // FILL/DRAIN sequencing with handshake outputs registered.
    always_ff @(posedge Clock or negedge Res_o_buf) begin
        if (!Res_o_buf) begin
            state       <= FILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (in_xfer && wr_idx == IDX_LAST) begin
                        state       <= DRAIN;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_xfer && rd_idx == IDX_LAST) begin
                        state       <= FILL;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= FILL;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef O_BUF_OVF_FLAG_EN
    logic ovf_q;

    // Sticky record of any word offered while draining.
    always_ff @(posedge Clock or negedge Res_o_buf) begin
        if (!Res_o_buf) begin
            ovf_q <= 1'b0;
        end else if (state == DRAIN && In_valid) begin
            ovf_q <= 1'b1;
        end
    end

    assign Ovf_err = ovf_q;
`endif

    assign In_ready  = in_ready_q;
    assign Out_valid = out_valid_q;
    assign Busy      = busy_q;
    assign Out_data  = entry[rd_idx];
    assign Out_last  = out_valid_q && (rd_idx == IDX_LAST);

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer.
// Overrun flag checks follow O_BUF_OVF_FLAG_EN.
module tb_output_buffer;

    localparam int DATA_W = 16;

    logic Clock = 1'b0;
    logic Res_o_buf;
    int   checks = 0;
    int   errors = 0;

    output_buffer_if #(.DATA_W(DATA_W)) bus ();

`ifdef O_BUF_OVF_FLAG_EN
    logic Ovf_err;
`endif

    output_buffer #(.DATA_W(DATA_W)) dut (
        .Clock     (Clock),
        .Res_o_buf (Res_o_buf),
        .In_valid  (bus.In_valid),
        .In_data   (bus.In_data),
        .In_ready  (bus.In_ready),
        .Out_valid (bus.Out_valid),
        .Out_data  (bus.Out_data),
        .Out_ready (bus.Out_ready),
        .Out_last  (bus.Out_last),
        .Busy      (bus.Busy)
`ifdef O_BUF_OVF_FLAG_EN
        ,
        .Ovf_err   (Ovf_err)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Res_o_buf    = 1'b0;
        bus.In_valid = 1'b0;
        bus.In_data  = '0;
        bus.Out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0 ||
            bus.Out_last !== 1'b0 || bus.Busy !== 1'b0 ||
            bus.Out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b last=%b busy=%b data=%h want 1 0 0 0 0000",
                     bus.In_ready, bus.Out_valid, bus.Out_last,
                     bus.Busy, bus.Out_data);
        end
`ifdef O_BUF_OVF_FLAG_EN
        checks++;
        if (Ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", Ovf_err);
        end
`endif
        Res_o_buf = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] exp;
        bus.Out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_fill_hs word %0d got rdy=%b vld=%b want 1 0",
                         i, bus.In_ready, bus.Out_valid);
            end
            bus.In_valid = 1'b1;
            bus.In_data  = 16'(16'h0011 * (i + 1));
            tick();
        end
        bus.In_valid = 1'b0;
        checks++;
        if (bus.Out_valid !== 1'b1 || bus.In_ready !== 1'b0 ||
            bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_drain_entry got vld=%b rdy=%b busy=%b want 1 0 1",
                     bus.Out_valid, bus.In_ready, bus.Busy);
        end
        for (int i = 0; i < 8; i++) begin
            exp = 16'(16'h0011 * (i + 1));
            checks++;
            if (bus.Out_data !== exp || bus.Out_last !== (i == 7)) begin
                errors++;
                $display("FAIL basic_drain word %0d got %h last=%b want %h last=%b",
                         i, bus.Out_data, bus.Out_last, exp, (i == 7));
            end
            tick();
        end
        checks++;
        if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0 ||
            bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_refill got rdy=%b vld=%b busy=%b want 1 0 0",
                     bus.In_ready, bus.Out_valid, bus.Busy);
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp;
        bus.Out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.In_valid = 1'b1;
            bus.In_data  = 16'(16'h0011 * (i + 1));
            tick();
        end
        bus.In_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.Out_valid !== 1'b1 || bus.Out_data !== 16'h0011 ||
                bus.Out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got vld=%b data=%h last=%b want 1 0011 0",
                         c, bus.Out_valid, bus.Out_data, bus.Out_last);
            end
            tick();
        end
        bus.Out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = 16'(16'h0011 * (i + 1));
            checks++;
            if (bus.Out_data !== exp || bus.Out_last !== (i == 7)) begin
                errors++;
                $display("FAIL stall_drain word %0d got %h last=%b want %h",
                         i, bus.Out_data, bus.Out_last, exp);
            end
            tick();
        end
    endtask

    task automatic test_toggle();
        logic [15:0] exp;
        bus.Out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            bus.In_valid = (c % 2 == 0);
            bus.In_data  = (c % 2 == 0) ? 16'(16'h0200 + c / 2)
                                        : 16'h0BAD;
            tick();
        end
        bus.In_valid  = 1'b0;
        checks++;
        if (bus.Out_valid !== 1'b1) begin
            errors++;
            $display("FAIL toggle_full got vld=%b want 1", bus.Out_valid);
        end
        bus.Out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = 16'(16'h0200 + i);
            checks++;
            if (bus.Out_valid !== 1'b1 || bus.Out_data !== exp) begin
                errors++;
                $display("FAIL toggle_drain word %0d got vld=%b data=%h want 1 %h",
                         i, bus.Out_valid, bus.Out_data, exp);
            end
            tick();
        end
        checks++;
        if (bus.Out_valid !== 1'b0) begin
            errors++;
            $display("FAIL toggle_extra got vld=%b want 0", bus.Out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        bus.Out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.In_valid = 1'b1;
            bus.In_data  = 16'(16'h0A00 + i);
            tick();
        end
        bus.In_data = 16'hDEAD;
        tick();
        bus.In_valid = 1'b0;
        checks++;
        if (bus.In_ready !== 1'b0 || bus.Out_data !== 16'h0A00) begin
            errors++;
            $display("FAIL ovf_ignored got rdy=%b data=%h want 0 0a00",
                     bus.In_ready, bus.Out_data);
        end
`ifdef O_BUF_OVF_FLAG_EN
        checks++;
        if (Ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b want 1", Ovf_err);
        end
`endif
        bus.Out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = 16'(16'h0A00 + i);
            checks++;
            if (bus.Out_data !== exp) begin
                errors++;
                $display("FAIL ovf_drain word %0d got %h want %h",
                         i, bus.Out_data, exp);
            end
            tick();
        end
`ifdef O_BUF_OVF_FLAG_EN
        checks++;
        if (Ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b want 1", Ovf_err);
        end
`endif
    endtask

    task automatic test_mid_reset();
        logic [15:0] exp;
        bus.Out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.In_valid = 1'b1;
            bus.In_data  = 16'(16'h0011 * (i + 1));
            tick();
        end
        bus.In_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = 16'(16'h0011 * (i + 1));
            checks++;
            if (bus.Out_data !== exp) begin
                errors++;
                $display("FAIL mid_pre word %0d got %h want %h",
                         i, bus.Out_data, exp);
            end
            tick();
        end
        Res_o_buf = 1'b0;
        #1;
        checks++;
        if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0 ||
            bus.Out_last !== 1'b0 || bus.Busy !== 1'b0 ||
            bus.Out_data !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b vld=%b last=%b busy=%b data=%h want 1 0 0 0 0000",
                     bus.In_ready, bus.Out_valid, bus.Out_last,
                     bus.Busy, bus.Out_data);
        end
`ifdef O_BUF_OVF_FLAG_EN
        checks++;
        if (Ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ovf got %b want 0", Ovf_err);
        end
`endif
        #1;
        Res_o_buf = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.In_valid = 1'b1;
            bus.In_data  = 16'(16'h0100 + i);
            tick();
        end
        bus.In_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = 16'(16'h0100 + i);
            checks++;
            if (bus.Out_valid !== 1'b1 || bus.Out_data !== exp ||
                bus.Out_last !== (i == 7)) begin
                errors++;
                $display("FAIL mid_new word %0d got vld=%b data=%h last=%b want 1 %h",
                         i, bus.Out_valid, bus.Out_data, bus.Out_last, exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        bus.Out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) begin
                bus.In_valid = 1'b1;
                bus.In_data  = 16'(16'h1000 * (b + 1) + i);
                tick();
            end
            bus.In_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                exp = 16'(16'h1000 * (b + 1) + i);
                checks++;
                if (bus.Out_valid !== 1'b1 || bus.Out_data !== exp ||
                    bus.Out_last !== (i == 7)) begin
                    errors++;
                    $display("FAIL b2b blk %0d word %0d got vld=%b data=%h last=%b want 1 %h",
                             b, i, bus.Out_valid, bus.Out_data,
                             bus.Out_last, exp);
                end
                tick();
            end
            checks++;
            if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_wrap blk %0d got rdy=%b vld=%b want 1 0",
                         b, bus.In_ready, bus.Out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_toggle();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
